aes_round_ctrl: RTL and testbench

Iterative AES round sequencer. Owns the 128-bit state register and the AddRoundKey XOR stage. Runs one block through NR rounds by driving an external combinational round-function datapath (SubBytes/ShiftRows/MixColumns) and an external round-key store. Sits between the block-level valid/ready stream and the round datapath; one block in flight at a time.

---
 rtl/aes_round_ctrl_if.sv | 28 ++
 rtl/aes_round_ctrl.sv | 76 +++++++
 tb/tb_aes_round_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_round_ctrl_if.sv
// Block stream plus round-datapath signals of the iterative AES round sequencer.
// The slave modport is the controller; the master modport is its environment.
interface aes_round_ctrl_if #(
    parameter int RKW = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [127:0]     data_in;
    logic             out_valid;
    logic             out_ready;
    logic [127:0]     data_out;
    logic             busy;
    logic [RKW-1:0]   rk_idx;
    logic [127:0]     rk_data;
    logic [127:0]     rf_in;
    logic             rf_final;
    logic [127:0]     rf_out;

    modport slave (
        input  in_valid, data_in, out_ready, rk_data, rf_out,
        output in_ready, out_valid, data_out, busy, rk_idx, rf_in, rf_final
    );

    modport master (
        output in_valid, data_in, out_ready, rk_data, rf_out,
        input  in_ready, out_valid, data_out, busy, rk_idx, rf_in, rf_final
    );
endinterface

// File: rtl/aes_round_ctrl.sv
// Iterative AES round sequencer: owns the state register and AddRoundKey, drives an
// external combinational round function and key store, one block in flight. NR in {10,12,14}.
module aes_round_ctrl #(
    parameter int NR  = 10,
    parameter int RKW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    aes_round_ctrl_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ROUND = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [RKW-1:0] LAST_ROUND = RKW'(NR);

    logic [1:0]     state_q, state_d;
    logic [RKW-1:0] round_q, round_d;
    logic [127:0]   blk_q,   blk_d;

    // NOTE: every signal gets a hold default first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        blk_d   = blk_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    blk_d   = bus.data_in ^ bus.rk_data;
                    round_d = RKW'(1);
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                blk_d = bus.rf_out ^ bus.rk_data;
                if (round_q == LAST_ROUND) begin
                    state_d = S_DONE;
                end else begin
                    round_d = round_q + RKW'(1);
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                    round_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                round_d = '0;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            round_q <= '0;
            blk_q   <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            blk_q   <= blk_d;
        end
    end

    // Handshake outputs decode the FSM state only; the counter is 0 in IDLE and NR in DONE.
    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.rk_idx    = round_q;
    assign bus.rf_final  = (state_q == S_ROUND) && (round_q == LAST_ROUND);
    assign bus.data_out  = blk_q;
    assign bus.rf_in     = blk_q;
endmodule

// File: tb/tb_aes_round_ctrl.sv
// Scoreboard bench for aes_round_ctrl with a stub round function (identity, optionally
// inverting in the final round) and a key store returning {16{rk_idx}}.
module tb_aes_round_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_round_ctrl_if #(.RKW(4)) b10 ();
    aes_round_ctrl_if #(.RKW(4)) b14 ();

    aes_round_ctrl #(.NR(10), .RKW(4)) dut10 (.clk(clk), .rst_n(rst_n), .bus(b10));
    aes_round_ctrl #(.NR(14), .RKW(4)) dut14 (.clk(clk), .rst_n(rst_n), .bus(b14));

    // Stub datapath: final-round inversion makes rf_final observable in data_out.
    logic inv_mode;
    assign b10.rk_data = {16{8'(b10.rk_idx)}};
    assign b10.rf_out  = (inv_mode && b10.rf_final) ? ~b10.rf_in : b10.rf_in;
    assign b14.rk_data = {16{8'(b14.rk_idx)}};
    assign b14.rf_out  = b14.rf_in;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [127:0] exp_q[$];
    int           acc_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: per-cycle control checks plus scoreboard pop on each output handshake.
    logic         prev_valid, prev_ready;
    logic [127:0] prev_data;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_ready = 1'b1;
            prev_data  = '0;
        end else begin
            check("busy_vs_in_ready", 128'(b10.busy), 128'(!b10.in_ready));
            if (b10.in_ready) begin
                check("idle_rk_idx", 128'(b10.rk_idx), 128'(0));
                check("idle_rf_final", 128'(b10.rf_final), 128'(0));
            end else if (!b10.out_valid) begin
                check("round_acc_depth", 128'(acc_q.size()), 128'(1));
                if (acc_q.size() != 0) begin
                    check("round_rk_idx", 128'(b10.rk_idx), 128'(cyc - acc_q[0]));
                    check("round_rf_final", 128'(b10.rf_final), 128'((cyc - acc_q[0]) == 10));
                end
            end else begin
                check("done_rk_idx", 128'(b10.rk_idx), 128'(10));
                check("done_rf_final", 128'(b10.rf_final), 128'(0));
                if (!prev_valid && acc_q.size() != 0)
                    check("latency", 128'(cyc - acc_q[0]), 128'(11));
                else if (prev_valid && !prev_ready)
                    check("hold_data_out", b10.data_out, prev_data);
                if (b10.out_ready) begin
                    check("exp_q_nonempty", 128'(exp_q.size() != 0), 128'(1));
                    if (exp_q.size() != 0) check("data_out", b10.data_out, exp_q.pop_front());
                    if (acc_q.size() != 0) void'(acc_q.pop_front());
                end
            end
            prev_valid = b10.out_valid;
            prev_ready = b10.out_ready;
            prev_data  = b10.data_out;
        end
    end

    task automatic offer(input logic [127:0] d, input logic [127:0] e);
        exp_q.push_back(e);
        b10.data_in  = d;
        b10.in_valid = 1'b1;
    endtask

    task automatic wait_accept(output int t);
        t = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (b10.in_ready) begin
                t = cyc;
                break;
            end
        end
        check("accept_in_time", 128'(t >= 0), 128'(1));
        if (t >= 0) acc_q.push_back(t);
        @(posedge clk);
        #1;
        b10.in_valid = 1'b0;
    endtask

    task automatic send(input logic [127:0] d, input logic [127:0] e, output int t);
        offer(d, e);
        wait_accept(t);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain", 128'(exp_q.size()), 128'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out_valid();
        int n;
        n = 0;
        while (!b10.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("out_valid_in_time", 128'(b10.out_valid), 128'(1));
    endtask

    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;

    initial begin
        int t0, t1, n;
        inv_mode      = 1'b0;
        b10.in_valid  = 1'b0;
        b10.data_in   = '0;
        b10.out_ready = 1'b1;
        b14.in_valid  = 1'b0;
        b14.data_in   = '0;
        b14.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 128'(b10.in_ready), 128'(1));
        check("rst_out_valid", 128'(b10.out_valid), 128'(0));
        check("rst_busy", 128'(b10.busy), 128'(0));
        check("rst_rk_idx", 128'(b10.rk_idx), 128'(0));
        check("rst_rf_final", 128'(b10.rf_final), 128'(0));
        check("rst_data_out", b10.data_out, 128'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Identity stub: result is data_in ^ (xor of keys 0..10) = data_in ^ {16{0b}}.
        send(128'h0, {16{8'h0b}}, t0);
        drain();
        send(PT, 128'h0b1a29384f5e6d7c8392a1b0c7d6e5f4, t0);
        drain();

        // Final-round inversion: result is ~(data_in ^ {16{0b}}).
        inv_mode = 1'b1;
        send(PT, 128'hf4e5d6c7b0a192837c6d5e4f38291a0b, t0);
        drain();
        send(128'h0, {16{8'hf4}}, t0);
        drain();
        inv_mode = 1'b0;

        // Backpressure: hold DONE for 20 cycles with a second block pending.
        b10.out_ready = 1'b0;
        send(PT, 128'h0b1a29384f5e6d7c8392a1b0c7d6e5f4, t0);
        wait_out_valid();
        @(posedge clk);
        #1;
        offer({16{8'h5a}}, {16{8'h51}});
        repeat (20) begin
            @(negedge clk);
            check("bp_in_ready", 128'(b10.in_ready), 128'(0));
            check("bp_out_valid", 128'(b10.out_valid), 128'(1));
        end
        @(posedge clk);
        #1;
        b10.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_in_ready", 128'(b10.in_ready), 128'(1));
        check("release_out_valid", 128'(b10.out_valid), 128'(0));
        wait_accept(t0);
        drain();

        // Back-to-back: in_valid and out_ready held high across two blocks.
        send(128'h0123456789abcdeffedcba9876543210, 128'h0a284e6c82a0c6e4f5d7b1937d5f391b, t0);
        send({16{8'h5a}}, {16{8'h51}}, t1);
        check("b2b_interval", 128'(t1 - t0), 128'(12));
        drain();

        // Reset at round 5: block discarded, outputs back to reset values immediately.
        send(PT, 128'h0b1a29384f5e6d7c8392a1b0c7d6e5f4, t0);
        repeat (4) @(posedge clk);
        #2;
        check("pre_rst_rk_idx", 128'(b10.rk_idx), 128'(5));
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 128'(b10.out_valid), 128'(0));
        check("mid_rst_in_ready", 128'(b10.in_ready), 128'(1));
        check("mid_rst_busy", 128'(b10.busy), 128'(0));
        check("mid_rst_rk_idx", 128'(b10.rk_idx), 128'(0));
        check("mid_rst_data_out", b10.data_out, 128'(0));
        exp_q.delete();
        acc_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(PT, 128'h0b1a29384f5e6d7c8392a1b0c7d6e5f4, t0);
        drain();

        // NR=14 build: xor of keys 0..14 is 0f, latency 15.
        b14.data_in  = PT;
        b14.in_valid = 1'b1;
        t0 = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (b14.in_ready) begin
                t0 = cyc;
                break;
            end
        end
        check("nr14_accept", 128'(t0 >= 0), 128'(1));
        @(posedge clk);
        #1;
        b14.in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!b14.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("nr14_latency", 128'(cyc - t0), 128'(15));
        check("nr14_data_out", b14.data_out, 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0);
        @(posedge clk);
        #1;
        check("nr14_back_idle", 128'(b14.in_ready), 128'(1));

        check("scoreboard_empty", 128'(exp_q.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule
